// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared widths, master indices and arbiter state encodings
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 26;
    localparam int SDRAM_DATA_W = 32;
    localparam int SDRAM_BE_W   = 4;
    localparam int SDRAM_ID_W   = 4;

    localparam logic [SDRAM_ID_W-1:0] SDRAM_ID_NONE = '0;

    localparam int MASTER_VGA    = 0;
    localparam int MASTER_ICACHE = 1;
    localparam int MASTER_DCACHE = 2;
    localparam int MASTER_BLIT   = 3;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OFFER = 1'b1
    } arb_state_t;

    // Master index i travels on the controller bus as ID i+1; ID 0 means nobody.
    function automatic logic [SDRAM_ID_W-1:0] master_id(input int idx);
        return SDRAM_ID_W'(idx + 1);
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - requester and controller signals of the SDRAM arbiter
interface sdram_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    import sdram_pkg::*;

    logic [NUM_MASTERS-1:0]              m_request;
    logic [NUM_MASTERS-1:0]              m_write;
    logic [SDRAM_ADDR_W*NUM_MASTERS-1:0] m_address;
    logic [SDRAM_DATA_W*NUM_MASTERS-1:0] m_wdata;
    logic [SDRAM_BE_W*NUM_MASTERS-1:0]   m_byte_en;
    logic [NUM_MASTERS-1:0]              m_burst;
    logic [NUM_MASTERS-1:0]              m_ack;
    logic [NUM_MASTERS-1:0]              m_rvalid;
    logic [NUM_MASTERS-1:0]              m_complete;
    logic [SDRAM_DATA_W-1:0]             m_rdata;

    logic                                sdram_request;
    logic [SDRAM_ID_W-1:0]               sdram_master;
    logic                                sdram_write;
    logic [SDRAM_ADDR_W-1:0]             sdram_address;
    logic [SDRAM_DATA_W-1:0]             sdram_wdata;
    logic [SDRAM_BE_W-1:0]               sdram_byte_en;
    logic                                sdram_burst;
    logic [SDRAM_DATA_W-1:0]             sdram_rdata;
    logic [SDRAM_ID_W-1:0]               sdram_valid;
    logic [SDRAM_ID_W-1:0]               sdram_complete;
    logic                                sdram_ready;

    modport slave (
        input  m_request, m_write, m_address, m_wdata, m_byte_en, m_burst,
        input  sdram_rdata, sdram_valid, sdram_complete, sdram_ready,
        output m_ack, m_rvalid, m_complete, m_rdata,
        output sdram_request, sdram_master, sdram_write, sdram_address,
        output sdram_wdata, sdram_byte_en, sdram_burst
    );

    modport master (
        output m_request, m_write, m_address, m_wdata, m_byte_en, m_burst,
        output sdram_rdata, sdram_valid, sdram_complete, sdram_ready,
        input  m_ack, m_rvalid, m_complete, m_rdata,
        input  sdram_request, sdram_master, sdram_write, sdram_address,
        input  sdram_wdata, sdram_byte_en, sdram_burst
    );

endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational find-first-eligible starting at a pointer, with wrap
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_eligible,
    input  logic [PW-1:0] i_ptr,
    output logic          o_found,
    output logic [PW-1:0] o_index
);

    int w_best_dist;
    int w_dist;

    // Each candidate's distance ahead of the pointer; the nearest eligible one wins.
    always_comb begin
        o_found     = 1'b0;
        o_index     = '0;
        w_best_dist = N;
        w_dist      = 0;
        for (int i = 0; i < N; i++) begin
            w_dist = i - int'(i_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + N;
            end
            if (i_eligible[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                o_found     = 1'b1;
                o_index     = PW'(i);
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin arbiter sharing one SDRAM controller port
// Build macro SDRAM_ARB_PRIORITY_EN: master 0 (VGA) wins whenever eligible.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int NUM_MASTERS = 4
) (
    input  logic           clock,
    input  logic           reset,
    sdram_arbiter_if.slave bus
);

    localparam int             PW       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [PW-1:0]  LAST_IDX = PW'(NUM_MASTERS - 1);

    arb_state_t               r_state;
    arb_state_t               w_state_nxt;
    logic [PW-1:0]            r_grant;
    logic [PW-1:0]            w_grant_nxt;
    logic [PW-1:0]            r_rr_ptr;
    logic [PW-1:0]            w_rr_ptr_nxt;
    logic [PW-1:0]            w_pick;
    logic [PW-1:0]            w_sel_idx;
    logic [PW-1:0]            w_grant_inc;
    logic [NUM_MASTERS-1:0]   r_busy;
    logic [NUM_MASTERS-1:0]   w_busy_set;
    logic [NUM_MASTERS-1:0]   w_eligible;
    logic [NUM_MASTERS-1:0]   w_valid_dec;
    logic [NUM_MASTERS-1:0]   w_complete_dec;
    logic [NUM_MASTERS-1:0]   w_ack;
    logic                     w_found;
    logic                     w_sel_found;
    logic                     w_adv_ptr;
    logic                     w_offer;
    logic                     w_grant_req;
    logic                     w_grant_write;
    logic                     w_grant_burst;
    logic [SDRAM_ADDR_W-1:0]  w_grant_addr;
    logic [SDRAM_DATA_W-1:0]  w_grant_wdata;
    logic [SDRAM_BE_W-1:0]    w_grant_be;

    assign w_eligible = bus.m_request & ~r_busy;

    rr_picker #(
        .N  (NUM_MASTERS),
        .PW (PW)
    ) u_picker (
        .i_eligible (w_eligible),
        .i_ptr      (r_rr_ptr),
        .o_found    (w_found),
        .o_index    (w_pick)
    );

`ifdef SDRAM_ARB_PRIORITY_EN
    // VGA grants bypass the rotation so the other masters keep their turn order.
    assign w_sel_found = w_eligible[MASTER_VGA] | w_found;
    assign w_sel_idx   = w_eligible[MASTER_VGA] ? PW'(MASTER_VGA) : w_pick;
    assign w_adv_ptr   = (r_grant != PW'(MASTER_VGA));
`else
    assign w_sel_found = w_found;
    assign w_sel_idx   = w_pick;
    assign w_adv_ptr   = 1'b1;
`endif

    always_comb begin
        w_grant_req   = 1'b0;
        w_grant_write = 1'b0;
        w_grant_burst = 1'b0;
        w_grant_addr  = '0;
        w_grant_wdata = '0;
        w_grant_be    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant == PW'(i)) begin
                w_grant_req   = bus.m_request[i];
                w_grant_write = bus.m_write[i];
                w_grant_burst = bus.m_burst[i];
                w_grant_addr  = bus.m_address[i*SDRAM_ADDR_W +: SDRAM_ADDR_W];
                w_grant_wdata = bus.m_wdata[i*SDRAM_DATA_W +: SDRAM_DATA_W];
                w_grant_be    = bus.m_byte_en[i*SDRAM_BE_W +: SDRAM_BE_W];
            end
        end
    end

    assign w_grant_inc = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;

    // A withdrawn request or a reset cycle must never be seen as accepted by the controller.
    assign w_offer = (r_state == ARB_OFFER) && w_grant_req && !reset;

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        w_ack        = '0;
        w_busy_set   = '0;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_sel_found) begin
                    w_grant_nxt = w_sel_idx;
                    w_state_nxt = ARB_OFFER;
                end
            end
            ARB_OFFER: begin
                if (!w_grant_req) begin
                    w_state_nxt = ARB_IDLE;
                end else if (w_offer && bus.sdram_ready) begin
                    w_ack[r_grant] = 1'b1;
                    w_state_nxt    = ARB_IDLE;
                    if (!w_grant_write) begin
                        w_busy_set[r_grant] = 1'b1;
                    end
                    if (w_adv_ptr) begin
                        w_rr_ptr_nxt = w_grant_inc;
                    end
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        w_valid_dec    = '0;
        w_complete_dec = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_valid_dec[i]    = (bus.sdram_valid == master_id(i));
            w_complete_dec[i] = (bus.sdram_complete == master_id(i));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ARB_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_busy   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_busy   <= (r_busy & ~w_complete_dec) | w_busy_set;
        end
    end

    assign bus.m_ack         = w_ack;
    assign bus.m_rvalid      = reset ? '0 : w_valid_dec;
    assign bus.m_complete    = reset ? '0 : w_complete_dec;
    assign bus.m_rdata       = bus.sdram_rdata;

    assign bus.sdram_request = w_offer;
    assign bus.sdram_master  = (r_state == ARB_OFFER) ? master_id(int'(r_grant)) : SDRAM_ID_NONE;
    assign bus.sdram_write   = w_grant_write;
    assign bus.sdram_address = w_grant_addr;
    assign bus.sdram_wdata   = w_grant_wdata;
    assign bus.sdram_byte_en = w_grant_be;
    assign bus.sdram_burst   = w_grant_burst;

endmodule
